// File: rtl/bmp_stream_writer_pkg.sv
// BMP constants, header layout lookup and writer state encoding.
// Shared by the stream writer and a future stream reader.
package bmp_stream_writer_pkg;

    localparam int unsigned BMP_HEADER_SIZE = 54;
    localparam int unsigned BMP_BPP         = 24;
    localparam int unsigned BMP_PPM         = 2835;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_PIXEL,
        ST_PAD,
        ST_LAST
    } bmp_state_e;

    function automatic int unsigned bmp_stride(input int unsigned w);
        return ((3 * w + 3) / 4) * 4;
    endfunction

    // Each header field is treated as a little-endian 32-bit word starting at base.
    function automatic logic [7:0] bmp_header_byte(
        input logic [5:0]  idx,
        input int unsigned w,
        input int unsigned h
    );
        logic [31:0] img;
        logic [31:0] fld;
        logic [5:0]  base;
        logic [1:0]  sh;
        img  = bmp_stride(w) * h;
        fld  = '0;
        base = '0;
        case (idx) inside
            [6'd0:6'd1]:   begin fld = 32'h0000_4D42;           base = 6'd0;  end
            [6'd2:6'd5]:   begin fld = img + BMP_HEADER_SIZE;   base = 6'd2;  end
            [6'd10:6'd13]: begin fld = BMP_HEADER_SIZE;         base = 6'd10; end
            [6'd14:6'd17]: begin fld = 32'd40;                  base = 6'd14; end
            [6'd18:6'd21]: begin fld = w;                       base = 6'd18; end
            [6'd22:6'd25]: begin fld = h;                       base = 6'd22; end
            [6'd26:6'd29]: begin fld = {16'(BMP_BPP), 16'd1};   base = 6'd26; end
            [6'd34:6'd37]: begin fld = img;                     base = 6'd34; end
            [6'd38:6'd41]: begin fld = BMP_PPM;                 base = 6'd38; end
            [6'd42:6'd45]: begin fld = BMP_PPM;                 base = 6'd42; end
            default:       begin fld = '0;                      base = '0;    end
        endcase
        sh = 2'(idx - base);
        return fld[{sh, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/bmp_stream_writer_if.sv
// Gray FIFO read port and BMP byte stream handshake.
interface bmp_stream_writer_if #(
    parameter int DWIDTH = 8
) ();
    logic [DWIDTH-1:0] fifo_dout;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [7:0]        out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        input  fifo_dout, fifo_empty, out_ready,
        output fifo_rd_en, out_data, out_valid, out_last
    );

    modport slave (
        output fifo_dout, fifo_empty, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_last
    );
endinterface

// File: rtl/bmp_header_rom.sv
// 54-byte BMP header lookup, fully folded from the image size.
module bmp_header_rom
    import bmp_stream_writer_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 540
) (
    input  logic [5:0] idx_i,
    output logic [7:0] byte_o
);
    logic [7:0] tbl [BMP_HEADER_SIZE];

    for (genvar i = 0; i < BMP_HEADER_SIZE; i++) begin : g_tbl
        assign tbl[i] = bmp_header_byte(6'(i), IMG_WIDTH, IMG_HEIGHT);
    end

    assign byte_o = (idx_i < 6'(BMP_HEADER_SIZE)) ? tbl[idx_i] : 8'h00;
endmodule

// File: rtl/bmp_stream_writer.sv
// Drains the gray FIFO and emits a complete 24-bit BMP file as bytes.
module bmp_stream_writer
    import bmp_stream_writer_pkg::*;
#(
    parameter int unsigned IMG_WIDTH  = 720,
    parameter int unsigned IMG_HEIGHT = 540,
    parameter int          DWIDTH     = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    bmp_stream_writer_if.master bus,
    output logic                busy,
    output logic                frame_done
);
    localparam int unsigned PAD      = bmp_stride(IMG_WIDTH) - 3 * IMG_WIDTH;
    localparam logic [11:0] LAST_COL = 12'(IMG_WIDTH - 1);
    localparam logic [11:0] LAST_ROW = 12'(IMG_HEIGHT - 1);
    localparam logic [1:0]  LAST_PAD = (PAD > 0) ? 2'(PAD - 1) : 2'd0;
    localparam logic [5:0]  LAST_HDR = 6'(BMP_HEADER_SIZE - 1);

    bmp_state_e        state_q, state_d;
    logic [5:0]        idx_q, idx_d;
    logic [11:0]       col_q, col_d;
    logic [11:0]       row_q, row_d;
    logic [1:0]        pad_q, pad_d;
    logic [1:0]        sub_q, sub_d;
    logic [DWIDTH-1:0] gray_q, gray_d;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              rd_en;
    logic              load;
    logic [7:0]        hdr_byte;

    bmp_header_rom #(
        .IMG_WIDTH (IMG_WIDTH),
        .IMG_HEIGHT(IMG_HEIGHT)
    ) u_rom (
        .idx_i (idx_q),
        .byte_o(hdr_byte)
    );

    // Next byte may load when the register is empty or being drained.
    assign load = !valid_q || bus.out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        col_d   = col_q;
        row_d   = row_q;
        pad_d   = pad_q;
        sub_d   = sub_q;
        gray_d  = gray_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        rd_en   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !done_q) begin
                    state_d = ST_HEADER;
                    data_d  = hdr_byte;
                    valid_d = 1'b1;
                    idx_d   = idx_q + 6'd1;
                end
            end
            ST_HEADER: begin
                if (load) begin
                    data_d  = hdr_byte;
                    valid_d = 1'b1;
                    idx_d   = idx_q + 6'd1;
                    if (idx_q == LAST_HDR) begin
                        state_d = ST_PIXEL;
                        idx_d   = '0;
                        col_d   = '0;
                        row_d   = '0;
                        sub_d   = '0;
                    end
                end
            end
            ST_PIXEL: begin
                if (load) begin
                    unique case (sub_q)
                        2'd0: begin
                            if (!bus.fifo_empty) begin
                                rd_en   = 1'b1;
                                gray_d  = bus.fifo_dout;
                                data_d  = 8'(bus.fifo_dout);
                                valid_d = 1'b1;
                                sub_d   = 2'd1;
                            end else begin
                                valid_d = 1'b0;
                            end
                        end
                        2'd1: begin
                            data_d  = 8'(gray_q);
                            valid_d = 1'b1;
                            sub_d   = 2'd2;
                        end
                        default: begin
                            data_d  = 8'(gray_q);
                            valid_d = 1'b1;
                            sub_d   = 2'd0;
                            if (col_q != LAST_COL) begin
                                col_d = col_q + 12'd1;
                            end else begin
                                col_d = '0;
                                if (PAD > 0) begin
                                    state_d = ST_PAD;
                                    pad_d   = '0;
                                end else if (row_q == LAST_ROW) begin
                                    last_d  = 1'b1;
                                    state_d = ST_LAST;
                                end else begin
                                    row_d = row_q + 12'd1;
                                end
                            end
                        end
                    endcase
                end
            end
            ST_PAD: begin
                if (load) begin
                    data_d  = 8'h00;
                    valid_d = 1'b1;
                    pad_d   = pad_q + 2'd1;
                    if (pad_q == LAST_PAD) begin
                        if (row_q == LAST_ROW) begin
                            last_d  = 1'b1;
                            state_d = ST_LAST;
                        end else begin
                            row_d   = row_q + 12'd1;
                            state_d = ST_PIXEL;
                        end
                    end
                end
            end
            ST_LAST: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            pad_q   <= '0;
            sub_q   <= '0;
            gray_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            col_q   <= col_d;
            row_q   <= row_d;
            pad_q   <= pad_d;
            sub_q   <= sub_d;
            gray_q  <= gray_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_data   = data_q;
    assign bus.out_valid  = valid_q;
    assign bus.out_last   = last_q;
    assign busy           = (state_q != ST_IDLE);
    assign frame_done     = done_q;
endmodule

// File: tb/tb_bmp_stream_writer.sv
// Scoreboard bench: 64x32 (no padding) and 5x2 (one pad byte per row) writers.
module tb_bmp_stream_writer;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset_a, reset_b, start_a, start_b;
    logic busy_a, busy_b, done_a, done_b;

    bmp_stream_writer_if #(.DWIDTH(8)) ifa ();
    bmp_stream_writer_if #(.DWIDTH(8)) ifb ();

    bmp_stream_writer #(.IMG_WIDTH(64), .IMG_HEIGHT(32), .DWIDTH(8)) dut_a (
        .clock(clock), .reset(reset_a), .start(start_a), .bus(ifa),
        .busy(busy_a), .frame_done(done_a)
    );

    bmp_stream_writer #(.IMG_WIDTH(5), .IMG_HEIGHT(2), .DWIDTH(8)) dut_b (
        .clock(clock), .reset(reset_b), .start(start_b), .bus(ifb),
        .busy(busy_b), .frame_done(done_b)
    );

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_a[$], exp_b[$], fifo_a[$], fifo_b[$];
    logic [7:0] cap_a [0:127];
    logic [7:0] cap_b [0:127];
    int nb_a, nb_b, pops_a, pops_b, dn_a, dn_b;
    logic pend_a = 1'b0;
    logic pend_b = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gray(input int d, input int i);
        return (d == 0) ? 8'(i * 7 + 3) : 8'(17 * (i + 1));
    endfunction

    task automatic push_exp(input int d, input logic [7:0] b);
        if (d == 0) exp_a.push_back(b);
        else exp_b.push_back(b);
    endtask

    task automatic push_le(input int d, input int unsigned v, input int n);
        for (int k = 0; k < n; k++) push_exp(d, 8'(v >> (8 * k)));
    endtask

    task automatic build(input int d);
        int unsigned w, h, stride, img;
        w = (d == 0) ? 64 : 5;
        h = (d == 0) ? 32 : 2;
        stride = ((3 * w + 3) / 4) * 4;
        img = stride * h;
        push_exp(d, 8'h42);
        push_exp(d, 8'h4D);
        push_le(d, 54 + img, 4);
        push_le(d, 0, 4);
        push_le(d, 54, 4);
        push_le(d, 40, 4);
        push_le(d, w, 4);
        push_le(d, h, 4);
        push_le(d, 1, 2);
        push_le(d, 24, 2);
        push_le(d, 0, 4);
        push_le(d, img, 4);
        push_le(d, 2835, 4);
        push_le(d, 2835, 4);
        push_le(d, 0, 8);
        for (int r = 0; r < int'(h); r++) begin
            for (int c = 0; c < int'(w); c++)
                for (int s = 0; s < 3; s++) push_exp(d, gray(d, r * int'(w) + c));
            for (int p = int'(3 * w); p < int'(stride); p++) push_exp(d, 8'h00);
        end
    endtask

    task automatic fill(input int d, input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            if (d == 0) fifo_a.push_back(gray(0, i));
            else fifo_b.push_back(gray(1, i));
        end
    endtask

    task automatic begin_frame(input int d);
        if (d == 0) begin nb_a = 0; pops_a = 0; dn_a = 0; end
        else begin nb_b = 0; pops_b = 0; dn_b = 0; end
        build(d);
    endtask

    task automatic pulse_start(input int d);
        @(posedge clock); #1;
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic mon_byte(input int d, input logic [7:0] data, input logic last);
        logic [7:0] e;
        logic el;
        int sz;
        sz = (d == 0) ? exp_a.size() : exp_b.size();
        chk(d == 0 ? "exp_avail_a" : "exp_avail_b", 32'(sz != 0), 32'd1);
        if (sz == 0) return;
        if (d == 0) begin
            e = exp_a.pop_front();
            el = (exp_a.size() == 0);
            if (nb_a < 128) cap_a[nb_a] = data;
            nb_a++;
        end else begin
            e = exp_b.pop_front();
            el = (exp_b.size() == 0);
            if (nb_b < 128) cap_b[nb_b] = data;
            nb_b++;
        end
        chk(d == 0 ? "byte_a" : "byte_b", 32'({last, data}), 32'({el, e}));
    endtask

    always @(negedge clock) begin
        ifa.fifo_empty = (fifo_a.size() == 0);
        ifa.fifo_dout  = (fifo_a.size() != 0) ? fifo_a[0] : 8'h00;
        ifb.fifo_empty = (fifo_b.size() == 0);
        ifb.fifo_dout  = (fifo_b.size() != 0) ? fifo_b[0] : 8'h00;
        #1;
        if (ifa.fifo_rd_en) begin
            chk("rd_empty_a", 32'(ifa.fifo_empty), 32'd0);
            pend_a = !ifa.fifo_empty;
        end
        if (ifb.fifo_rd_en) begin
            chk("rd_empty_b", 32'(ifb.fifo_empty), 32'd0);
            pend_b = !ifb.fifo_empty;
        end
        if (ifa.out_valid && ifa.out_ready) mon_byte(0, ifa.out_data, ifa.out_last);
        if (ifb.out_valid && ifb.out_ready) mon_byte(1, ifb.out_data, ifb.out_last);
        if (done_a) dn_a++;
        if (done_b) dn_b++;
    end

    always @(posedge clock) begin
        #1;
        if (pend_a) begin pend_a = 1'b0; void'(fifo_a.pop_front()); pops_a++; end
        if (pend_b) begin pend_b = 1'b0; void'(fifo_b.pop_front()); pops_b++; end
    end

    task automatic wait_nb(input int d, input int n);
        int i;
        i = 0;
        while (((d == 0) ? nb_a : nb_b) < n && i < 20000) begin
            @(negedge clock); #2;
            i++;
        end
        chk("wait_nb", 32'(((d == 0) ? nb_a : nb_b) >= n), 32'd1);
    endtask

    task automatic end_frame(input int d, input int bytes, input int pops);
        int i;
        i = 0;
        while (((d == 0) ? dn_a : dn_b) == 0 && i < 20000) begin
            @(negedge clock); #2;
            i++;
        end
        chk("done_seen", 32'(((d == 0) ? dn_a : dn_b) != 0), 32'd1);
        // start lands on the frame_done cycle and must be dropped
        if (d == 0) start_a = 1'b1; else start_b = 1'b1;
        @(posedge clock); #1;
        start_a = 1'b0;
        start_b = 1'b0;
        repeat (4) @(negedge clock);
        #2;
        if (d == 0) begin
            chk("busy_after_a", 32'({busy_a, ifa.out_valid}), 32'd0);
            chk("bytes_a", 32'(nb_a), 32'(bytes));
            chk("pops_a", 32'(pops_a), 32'(pops));
            chk("done_cnt_a", 32'(dn_a), 32'd1);
            chk("exp_left_a", 32'(exp_a.size()), 32'd0);
        end else begin
            chk("busy_after_b", 32'({busy_b, ifb.out_valid}), 32'd0);
            chk("bytes_b", 32'(nb_b), 32'(bytes));
            chk("pops_b", 32'(pops_b), 32'(pops));
            chk("done_cnt_b", 32'(dn_b), 32'd1);
            chk("exp_left_b", 32'(exp_b.size()), 32'd0);
        end
    endtask

    logic [7:0] lit_lo [6]   = '{8'h42, 8'h4D, 8'h36, 8'h18, 8'h00, 8'h00};
    logic [7:0] lit_hi [8]   = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h20, 8'h00, 8'h00, 8'h00};
    logic [7:0] lit_b  [6]   = '{8'h56, 8'h00, 8'h11, 8'h55, 8'h00, 8'h66};
    int         lit_bi [6]   = '{2, 3, 54, 68, 69, 70};

    initial begin
        int p0, n0;
        reset_a = 1'b0;
        reset_b = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        ifa.out_ready = 1'b1;
        ifb.out_ready = 1'b1;
        repeat (3) @(negedge clock);
        #2;
        chk("rst_a", 32'({ifa.out_valid, ifa.out_last, ifa.out_data, ifa.fifo_rd_en, busy_a, done_a}), 32'd0);
        chk("rst_b", 32'({ifb.out_valid, ifb.out_last, ifb.out_data, ifb.fifo_rd_en, busy_b, done_b}), 32'd0);
        @(posedge clock); #1;
        reset_a = 1'b1;
        reset_b = 1'b1;

        // 64x32 prefilled, continuous ready
        begin_frame(0);
        fill(0, 0, 2048);
        pulse_start(0);
        chk("first_byte_a", 32'({ifa.out_valid, ifa.out_data, busy_a}), 32'({1'b1, 8'h42, 1'b1}));
        end_frame(0, 6198, 2048);
        for (int i = 0; i < 6; i++) chk("hdr_lo_a", 32'(cap_a[i]), 32'(lit_lo[i]));
        for (int i = 0; i < 8; i++) chk("hdr_hi_a", 32'(cap_a[18 + i]), 32'(lit_hi[i]));

        // reset mid-frame, then a clean frame
        begin_frame(0);
        fill(0, 0, 2048);
        pulse_start(0);
        wait_nb(0, 100);
        reset_a = 1'b0;
        #1;
        chk("rst_mid_a", 32'({ifa.out_valid, ifa.out_last, ifa.out_data, ifa.fifo_rd_en, busy_a, done_a}), 32'd0);
        exp_a.delete();
        fifo_a.delete();
        pend_a = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_a = 1'b1;
        begin_frame(0);
        fill(0, 0, 2048);
        pulse_start(0);
        end_frame(0, 6198, 2048);
        chk("restart_bm", 32'({cap_a[0], cap_a[1]}), 32'h424D);

        // start pulsed while busy
        begin_frame(0);
        fill(0, 0, 2048);
        pulse_start(0);
        wait_nb(0, 30);
        pulse_start(0);
        end_frame(0, 6198, 2048);

        // 5x2 with padding
        begin_frame(1);
        fill(1, 0, 10);
        pulse_start(1);
        end_frame(1, 86, 10);
        for (int i = 0; i < 6; i++) chk("lit_b", 32'(cap_b[lit_bi[i]]), 32'(lit_b[i]));

        // 5x2 with a sink stall on sub 1 and an empty FIFO at row 1
        begin_frame(1);
        fill(1, 0, 5);
        pulse_start(1);
        wait_nb(1, 55);
        @(posedge clock); #1;
        ifb.out_ready = 1'b0;
        p0 = pops_b;
        n0 = nb_b;
        repeat (3) begin
            @(negedge clock); #2;
            chk("stall_b", 32'({ifb.out_valid, ifb.out_data, ifb.fifo_rd_en}), 32'({1'b1, 8'h11, 1'b0}));
        end
        chk("stall_pops", 32'(pops_b), 32'(p0));
        chk("stall_cnt", 32'(nb_b), 32'(n0));
        @(posedge clock); #1;
        ifb.out_ready = 1'b1;
        wait_nb(1, 70);
        repeat (2) @(negedge clock);
        repeat (10) begin
            @(negedge clock); #2;
            chk("empty_wait_b", 32'({ifb.out_valid, ifb.fifo_rd_en}), 32'd0);
        end
        fill(1, 5, 5);
        end_frame(1, 86, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
